// File: rtl/datapath_pkg.sv
// Shared datapath types for the register-file write side.
package datapath_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Result handshakes from ALU/load unit plus the register file write port.
interface writeback_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Alu_Valid;
  logic                  Alu_Ready;
  logic [ADDR_WIDTH-1:0] Alu_Register;
  logic [DATA_WIDTH-1:0] Alu_Data;
  logic                  Mem_Valid;
  logic                  Mem_Ready;
  logic [ADDR_WIDTH-1:0] Mem_Register;
  logic [DATA_WIDTH-1:0] Mem_Data;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Write_Register;
  logic [DATA_WIDTH-1:0] Write_Data;

  modport master (
    output Alu_Valid, Alu_Register, Alu_Data,
    output Mem_Valid, Mem_Register, Mem_Data,
    input  Alu_Ready, Mem_Ready,
    input  RegWrite, Write_Register, Write_Data
  );

  modport slave (
    input  Alu_Valid, Alu_Register, Alu_Data,
    input  Mem_Valid, Mem_Register, Mem_Data,
    output Alu_Ready, Mem_Ready,
    output RegWrite, Write_Register, Write_Data
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular result buffer; pops the head every cycle it holds anything.
module wb_fifo
  import datapath_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          push,
  input  wb_entry_t     push_entry,
  output wb_entry_t     head_entry,
  output wb_entry_t     entries [DEPTH],
  output logic [CW-1:0] Count
);
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          pop;
  wb_entry_t     mem [DEPTH];

  assign pop        = (Count != '0);
  assign head_entry = mem[head_ptr];
  assign entries    = mem;

  // Push and pop never hit the same slot: that needs Count==0 (no pop) or full (no push).
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      Count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= '{valid: 1'b1, index: push_entry.index, data: push_entry.data};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + 1'b1;
      end
      if (push && !pop)      Count <= Count + 1'b1;
      else if (!push && pop) Count <= Count - 1'b1;
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// Arbitrates ALU/load results into wb_fifo, drives the register file write port
// and reports pending writes for decode hazard stalls.
module writeback_queue
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  writeback_queue_if.slave      bus,
  input  logic [ADDR_WIDTH-1:0] Query_Register1,
  input  logic [ADDR_WIDTH-1:0] Query_Register2,
  output logic                  Pending1,
  output logic                  Pending2,
  output logic [CW-1:0]         Count
);
  logic      full;
  logic      mem_fire;
  logic      alu_fire;
  logic      push;
  wb_entry_t push_entry;
  wb_entry_t head_entry;
  wb_entry_t entries [DEPTH];

  assign full          = (Count == CW'(DEPTH));
  assign bus.Mem_Ready = Reset_n && !full;
  assign bus.Alu_Ready = Reset_n && !full && !bus.Mem_Valid;
  assign mem_fire      = bus.Mem_Valid && bus.Mem_Ready;
  assign alu_fire      = bus.Alu_Valid && bus.Alu_Ready;

  // Writes to r0 are acknowledged but dropped here.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (mem_fire) begin
      push_entry.index = bus.Mem_Register;
      push_entry.data  = bus.Mem_Data;
      push             = (bus.Mem_Register != REG_ZERO);
    end else if (alu_fire) begin
      push_entry.index = bus.Alu_Register;
      push_entry.data  = bus.Alu_Data;
      push             = (bus.Alu_Register != REG_ZERO);
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .push       (push),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .entries    (entries),
    .Count      (Count)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      bus.RegWrite       <= 1'b0;
      bus.Write_Register <= '0;
      bus.Write_Data     <= '0;
    end else if (Count != '0) begin
      bus.RegWrite       <= 1'b1;
      bus.Write_Register <= head_entry.index;
      bus.Write_Data     <= head_entry.data;
    end else begin
      bus.RegWrite <= 1'b0;
    end
  end

  // The output stage still counts: the register file commits it on the next edge.
  always_comb begin
    Pending1 = bus.RegWrite && (bus.Write_Register == Query_Register1);
    Pending2 = bus.RegWrite && (bus.Write_Register == Query_Register2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && entries[i].index == Query_Register1) Pending1 = 1'b1;
      if (entries[i].valid && entries[i].index == Query_Register2) Pending2 = 1'b1;
    end
    if (Query_Register1 == REG_ZERO) Pending1 = 1'b0;
    if (Query_Register2 == REG_ZERO) Pending2 = 1'b0;
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized scoreboard bench for writeback_queue against a queue-based model.
module tb_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic       Clock;
  logic       Reset_n;
  logic [4:0] Query_Register1;
  logic [4:0] Query_Register2;
  logic       Pending1;
  logic       Pending2;
  logic [2:0] Count;

  writeback_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .bus             (bus),
    .Query_Register1 (Query_Register1),
    .Query_Register2 (Query_Register2),
    .Pending1        (Pending1),
    .Pending2        (Pending2),
    .Count           (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Model: buffered results, the output stage, and the scoreboard of expected writes.
  wr_t         mfifo[$];
  wr_t         sb[$];
  bit          mout_v   = 1'b0;
  logic [4:0]  mlast_r  = '0;
  logic [31:0] mlast_d  = '0;
  bit          rec_rst  = 1'b1;
  bit          rec_fire = 1'b0;
  wr_t         rec_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pending(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (mout_v && mlast_r == q) return 1'b1;
    foreach (mfifo[i]) if (mfifo[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rst_n,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md,
                      input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic [4:0] q1, input logic [4:0] q2);
    wr_t w;
    bit  rdy;
    @(posedge Clock);
    if (rec_rst) begin
      mfifo.delete();
      sb.delete();
      mout_v  = 1'b0;
      mlast_r = '0;
      mlast_d = '0;
    end else begin
      if (mfifo.size() > 0) begin
        w       = mfifo.pop_front();
        mout_v  = 1'b1;
        mlast_r = w.r;
        mlast_d = w.d;
      end else begin
        mout_v = 1'b0;
      end
      if (rec_fire) begin
        mfifo.push_back(rec_item);
        sb.push_back(rec_item);
      end
    end
    #1;
    Reset_n          = rst_n;
    bus.Mem_Valid    = mv;
    bus.Mem_Register = mr;
    bus.Mem_Data     = md;
    bus.Alu_Valid    = av;
    bus.Alu_Register = ar;
    bus.Alu_Data     = ad;
    Query_Register1  = q1;
    Query_Register2  = q2;
    #3;
    rec_rst  = !rst_n;
    rec_fire = 1'b0;
    rdy      = rst_n && (mfifo.size() != DEPTH);
    if (mv && rdy) begin
      rec_fire   = (mr != 5'd0);
      rec_item.r = mr;
      rec_item.d = md;
    end else if (av && rdy && !mv) begin
      rec_fire   = (ar != 5'd0);
      rec_item.r = ar;
      rec_item.d = ad;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  // Monitor: compares the DUT against the model away from the active edge.
  initial begin
    wr_t w;
    bit  mrdy;
    forever begin
      @(negedge Clock);
      mrdy = Reset_n && (mfifo.size() != DEPTH);
      chk("count", 64'(Count), 64'(mfifo.size()));
      total++;
      assert (Count <= 3'(DEPTH)) else begin
        bad++;
        $display("FAIL count_bound actual=%0d required<=%0d", Count, DEPTH);
      end
      chk("mem_ready", 64'(bus.Mem_Ready), 64'(mrdy));
      chk("alu_ready", 64'(bus.Alu_Ready), 64'(mrdy && !bus.Mem_Valid));
      chk("regwrite", 64'(bus.RegWrite), 64'(mout_v));
      if (bus.RegWrite === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_spurious_write actual=reg%0d required=no_write", bus.Write_Register);
        end else begin
          w = sb.pop_front();
          chk("sb_reg", 64'(bus.Write_Register), 64'(w.r));
          chk("sb_data", 64'(bus.Write_Data), 64'(w.d));
        end
      end
      chk("write_reg_hold", 64'(bus.Write_Register), 64'(mlast_r));
      chk("write_data_hold", 64'(bus.Write_Data), 64'(mlast_d));
      chk("pending1", 64'(Pending1), 64'(model_pending(Query_Register1)));
      chk("pending2", 64'(Pending2), 64'(model_pending(Query_Register2)));
    end
  end

  initial begin
    Reset_n          = 1'b0;
    bus.Mem_Valid    = 1'b0;
    bus.Mem_Register = '0;
    bus.Mem_Data     = '0;
    bus.Alu_Valid    = 1'b0;
    bus.Alu_Register = '0;
    bus.Alu_Data     = '0;
    Query_Register1  = '0;
    Query_Register2  = '0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // Single ALU result
    step(1, 0, 0, 0, 1, 5'd8, 32'h0000_00FF, 5'd8, 5'd0);
    idle(3, 5'd8, 5'd0);

    // Load priority over ALU
    step(1, 1, 5'd9, 32'hDEAD_BEEF, 1, 5'd10, 32'd1, 5'd9, 5'd10);
    step(1, 0, 0, 0, 1, 5'd10, 32'd1, 5'd9, 5'd10);
    idle(3, 5'd9, 5'd10);

    // Back-to-back ALU burst
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 1, 5'(i), 32'(i * 16 + 3), 5'(i), 5'd3);
    idle(3, 5'd5, 5'd4);

    // r0 is acknowledged but dropped
    step(1, 0, 0, 0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    idle(3, 5'd0, 5'd0);

    // Duplicate destination
    step(1, 0, 0, 0, 1, 5'd7, 32'hAAAA_0001, 5'd0, 5'd7);
    step(1, 0, 0, 0, 1, 5'd7, 32'hAAAA_0002, 5'd0, 5'd7);
    idle(4, 5'd0, 5'd7);

    // Reset mid-operation
    step(1, 1, 5'd11, 32'h11, 0, 0, 0, 5'd11, 5'd12);
    step(1, 1, 5'd12, 32'h12, 0, 0, 0, 5'd11, 5'd12);
    step(1, 0, 0, 0, 1, 5'd13, 32'h13, 5'd11, 5'd13);
    step(0, 0, 0, 0, 1, 5'd14, 32'h14, 5'd11, 5'd12);
    idle(3, 5'd11, 5'd12);

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(63) != 0,
           $urandom_range(1), 5'($urandom_range(7)), $urandom,
           $urandom_range(1), 5'($urandom_range(7)), $urandom,
           5'($urandom_range(7)), 5'($urandom_range(7)));
    end
    idle(6, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
